// File: rtl/gray_pkg.sv
// ============================================================================
// Module      : gray_pkg
// Description : Shared Gray/binary helpers and lock FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gray_pkg;

  // Helpers work on a zero-extended word; leading zeros convert to zeros.
  localparam int unsigned GRAY_MAX_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } lock_state_e;

  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = g[i] ^ b[i+1];
    end
    return b;
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/gray_decoder_if.sv
// ============================================================================
// Module      : gray_decoder_if
// Description : Sample input and classified output bundle of gray_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface gray_decoder_if #(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8
);
  logic [WIDTH-1:0]     gray_in;
  logic                 gray_vld;
  logic [WIDTH-1:0]     bin_out;
  logic                 bin_vld;
  logic                 step;
  logic                 hold;
  logic                 err;
  logic                 locked;
  logic [ERR_CNT_W-1:0] err_cnt;

  modport master (
    output gray_in, gray_vld,
    input  bin_out, bin_vld, step, hold, err, locked, err_cnt
  );

  modport slave (
    input  gray_in, gray_vld,
    output bin_out, bin_vld, step, hold, err, locked, err_cnt
  );
endinterface

`default_nettype wire

// File: rtl/gray_decoder_gray2bin_comb.sv
// ============================================================================
// Module      : gray2bin_comb
// Description : Combinational Gray-to-binary converter, WIDTH-generic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gray2bin_comb #(
  parameter int WIDTH = 4
) (
  input  wire logic [WIDTH-1:0] gray_i,
  output      logic [WIDTH-1:0] bin_o
);

  // Each binary bit is the parity of its Gray bit and all bits above it.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin_o[i] = ^gray_i[WIDTH-1:i];
  end

endmodule

`default_nettype wire

// File: rtl/gray_decoder.sv
// ============================================================================
// Module      : gray_decoder
// Description : Two-stage Gray sample decoder with step/hold/err classify,
//               lock FSM and saturating error counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gray_decoder
  import gray_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int LOCK_STEPS = 4,
  parameter int ERR_CNT_W  = 8
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  gray_decoder_if.slave    bus
);

  localparam int               RUN_W        = 4;
  localparam logic [RUN_W-1:0] c_lock_steps = RUN_W'(LOCK_STEPS);

  logic [WIDTH-1:0]     gray_q;
  logic                 vld_q;
  logic [WIDTH-1:0]     bin_out_q;
  logic                 bin_vld_q;
  logic                 step_q, step_d;
  logic                 hold_q, hold_d;
  logic                 err_q,  err_d;
  logic [RUN_W-1:0]     run_cnt_q, run_cnt_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  lock_state_e          state_q, state_d;

  logic [WIDTH-1:0]     w_bin;
  logic                 w_is_step;
  logic                 w_is_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gray_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= bus.gray_vld;
      if (bus.gray_vld) begin
        gray_q <= bus.gray_in;
      end
    end
  end

  gray2bin_comb #(
    .WIDTH (WIDTH)
  ) u_g2b (
    .gray_i (gray_q),
    .bin_o  (w_bin)
  );

  // bin_out only changes on accepted samples, so it doubles as prev_bin.
  assign w_is_step = (w_bin == bin_out_q + 1'b1);
  assign w_is_hold = (w_bin == bin_out_q);

  always_comb begin
    state_d   = state_q;
    run_cnt_d = run_cnt_q;
    step_d    = 1'b0;
    hold_d    = 1'b0;
    err_d     = 1'b0;
    if (vld_q) begin
      unique case (state_q)
        IDLE: begin
          state_d   = ACQ;
          run_cnt_d = '0;
        end
        ACQ: begin
          if (w_is_step) begin
            step_d = 1'b1;
            if (run_cnt_q + 1'b1 == c_lock_steps) begin
              state_d   = LOCKED;
              run_cnt_d = '0;
            end else begin
              run_cnt_d = run_cnt_q + 1'b1;
            end
          end else if (w_is_hold) begin
            hold_d = 1'b1;
          end else begin
            err_d     = 1'b1;
            run_cnt_d = '0;
          end
        end
        LOCKED: begin
          if (w_is_step) begin
            step_d = 1'b1;
          end else if (w_is_hold) begin
            hold_d = 1'b1;
          end else begin
            err_d     = 1'b1;
            state_d   = ACQ;
            run_cnt_d = '0;
          end
        end
        default: begin
          state_d   = IDLE;
          run_cnt_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      run_cnt_q <= '0;
      bin_out_q <= '0;
      bin_vld_q <= 1'b0;
      step_q    <= 1'b0;
      hold_q    <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      run_cnt_q <= run_cnt_d;
      bin_vld_q <= vld_q;
      step_q    <= step_d;
      hold_q    <= hold_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      if (vld_q) begin
        bin_out_q <= w_bin;
      end
    end
  end

  assign bus.bin_out = bin_out_q;
  assign bus.bin_vld = bin_vld_q;
  assign bus.step    = step_q;
  assign bus.hold    = hold_q;
  assign bus.err     = err_q;
  assign bus.locked  = (state_q == LOCKED);
  assign bus.err_cnt = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_gray_decoder.sv
// ============================================================================
// Module      : tb_gray_decoder
// Description : Self-checking bench for gray_decoder (table + model + random).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gray_decoder;

  localparam int W  = 4;
  localparam int LS = 4;
  localparam int EW = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  gray_decoder_if #(.WIDTH(W), .ERR_CNT_W(EW)) bus ();

  gray_decoder #(
    .WIDTH      (W),
    .LOCK_STEPS (LS),
    .ERR_CNT_W  (EW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0] bin;
    logic       vld;
    logic       stp;
    logic       hld;
    logic       er;
    logic       lck;
    logic [7:0] ec;
  } obs_t;

  typedef struct {
    bit         v;
    logic [3:0] g;
    obs_t       exp;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  // Reference model state: value history, consecutive good steps, lock, errors.
  bit         m_have;
  int         m_prev;
  int         m_run;
  bit         m_lock;
  int         m_errs;
  bit         pend_v;
  logic [3:0] pend_g;
  obs_t       m_out;

  function automatic logic [3:0] m_g2b(input logic [3:0] g);
    logic [3:0] b;
    for (int i = 0; i < 4; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  function automatic logic [3:0] b2g(input int b);
    logic [3:0] x;
    x = 4'(b % 16);
    return x ^ (x >> 1);
  endfunction

  function automatic obs_t sample();
    obs_t s;
    s = {bus.bin_out, bus.bin_vld, bus.step, bus.hold, bus.err, bus.locked, bus.err_cnt};
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_have = 1'b0;
    m_prev = 0;
    m_run  = 0;
    m_lock = 1'b0;
    m_errs = 0;
    pend_v = 1'b0;
    pend_g = '0;
    m_out  = '0;
  endtask

  task automatic model_eval();
    int b;
    m_out.vld = pend_v;
    m_out.stp = 1'b0;
    m_out.hld = 1'b0;
    m_out.er  = 1'b0;
    if (pend_v) begin
      b = int'(m_g2b(pend_g));
      if (m_have) begin
        if (b == (m_prev + 1) % 16) begin
          m_out.stp = 1'b1;
          if (!m_lock) begin
            m_run++;
            if (m_run >= LS) begin
              m_lock = 1'b1;
              m_run  = 0;
            end
          end
        end else if (b == m_prev) begin
          m_out.hld = 1'b1;
        end else begin
          m_out.er = 1'b1;
          m_lock   = 1'b0;
          m_run    = 0;
          if (m_errs < 255) m_errs++;
        end
      end
      m_have    = 1'b1;
      m_prev    = b;
      m_out.bin = 4'(b);
    end
    m_out.lck = m_lock;
    m_out.ec  = 8'(m_errs);
  endtask

  task automatic tick(input bit v, input logic [3:0] g, input string name);
    @(negedge clk);
    bus.gray_in  = g;
    bus.gray_vld = v;
    @(posedge clk);
    #1;
    model_eval();
    pend_v = v;
    pend_g = g;
    check(name, 32'(sample()), 32'(m_out));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n        = 1'b0;
    bus.gray_vld = 1'b0;
    bus.gray_in  = '0;
    model_reset();
    #1;
    check("reset_state", 32'(sample()), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t tbl[10];
  int   steps, lock_at, holds, errs;
  int   last_b;

  initial begin
    rst_n        = 1'b1;
    bus.gray_in  = '0;
    bus.gray_vld = 1'b0;
    model_reset();

    tbl[0] = '{1'b1, 4'b0110, {4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0}};
    tbl[1] = '{1'b0, 4'b0000, {4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0}};
    tbl[2] = '{1'b1, 4'b0111, {4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0}};
    tbl[3] = '{1'b1, 4'b0101, {4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0}};
    tbl[4] = '{1'b1, 4'b0100, {4'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0}};
    tbl[5] = '{1'b1, 4'b1100, {4'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0}};
    tbl[6] = '{1'b1, 4'b1100, {4'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0}};
    tbl[7] = '{1'b1, 4'b0011, {4'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0}};
    tbl[8] = '{1'b0, 4'b0000, {4'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1}};
    tbl[9] = '{1'b0, 4'b0000, {4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1}};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick(tbl[i].v, tbl[i].g, "tbl_model");
      check($sformatf("tbl_row%0d", i), 32'(sample()), 32'(tbl[i].exp));
    end

    // Full up-count through all 16 codes and the wrap back to zero.
    do_reset();
    steps   = 0;
    lock_at = -1;
    for (int k = 0; k <= 16; k++) begin
      tick(1'b1, b2g(k), "upcount");
      if (bus.step) steps++;
      if (bus.locked && lock_at < 0) lock_at = steps;
    end
    for (int k = 0; k < 2; k++) begin
      tick(1'b0, 4'b0000, "upcount_flush");
      if (bus.step) steps++;
      if (bus.locked && lock_at < 0) lock_at = steps;
    end
    check("upcount_steps", 32'(steps), 32'(16));
    check("lock_on_4th_step", 32'(lock_at), 32'(4));
    check("upcount_errcnt", 32'(bus.err_cnt), 32'(0));

    // Locked at 0: step up to 5, then jump to 8 and relock.
    for (int k = 1; k <= 5; k++) tick(1'b1, b2g(k), "lockerr_pre");
    tick(1'b1, 4'b1100, "lockerr_jump");
    tick(1'b1, b2g(9), "lockerr_seen");
    check("lockerr_err", 32'({bus.err, bus.locked}), 32'(2'b10));
    check("lockerr_cnt", 32'(bus.err_cnt), 32'(1));
    for (int k = 10; k <= 12; k++) tick(1'b1, b2g(k), "relock");
    tick(1'b0, 4'b0000, "relock_last");
    check("relock_locked", 32'(bus.locked), 32'(1));

    // Hold repeats followed by a decrement.
    do_reset();
    holds = 0;
    errs  = 0;
    tick(1'b1, 4'b0000, "hold_seq");
    tick(1'b1, 4'b0001, "hold_seq");
    for (int k = 0; k < 3; k++) begin
      tick(1'b1, 4'b0011, "hold_seq");
      if (bus.hold) holds++;
    end
    tick(1'b1, 4'b0001, "hold_seq");
    if (bus.hold) holds++;
    check("hold_bin", 32'(bus.bin_out), 32'(2));
    tick(1'b0, 4'b0000, "hold_seq");
    if (bus.hold) holds++;
    if (bus.err) errs++;
    tick(1'b0, 4'b0000, "hold_seq");
    if (bus.err) errs++;
    check("hold_count", 32'(holds), 32'(2));
    check("decrement_err", 32'(errs), 32'(1));

    // 300 errors saturate the counter, which then stays put.
    for (int k = 0; k < 300; k++) tick(1'b1, (k % 2 == 0) ? 4'b0000 : 4'b1100, "sat");
    tick(1'b0, 4'b0000, "sat_flush");
    check("errcnt_sat", 32'(bus.err_cnt), 32'(255));
    for (int k = 0; k < 6; k++) tick(1'b1, (k % 2 == 0) ? 4'b0000 : 4'b1100, "sat_more");
    tick(1'b0, 4'b0000, "sat_flush2");
    check("errcnt_stays", 32'(bus.err_cnt), 32'(255));

    // Asynchronous reset mid-stream while locked, with a sample in flight.
    do_reset();
    for (int k = 0; k <= 5; k++) tick(1'b1, b2g(k), "mid_pre");
    tick(1'b1, b2g(6), "mid_inflight");
    check("mid_locked_before", 32'(bus.locked), 32'(1));
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", 32'(sample()), 32'(0));
    model_reset();
    @(negedge clk);
    bus.gray_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b0, 4'b0000, "mid_discard");
    check("mid_no_vld", 32'(bus.bin_vld), 32'(0));
    tick(1'b1, b2g(7), "mid_first");
    tick(1'b0, 4'b0000, "mid_first_out");
    check("mid_first_noflag", 32'({bus.bin_vld, bus.step, bus.hold, bus.err}), 32'(4'b1000));

    // Random traffic: mostly counting, with holds, jumps and idle cycles.
    do_reset();
    last_b = 0;
    for (int k = 0; k < 3000; k++) begin
      int  r;
      bit  v;
      v = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 9);
      if (v) begin
        if (r < 6)      last_b = (last_b + 1) % 16;
        else if (r < 8) last_b = last_b;
        else            last_b = $urandom_range(0, 15);
      end
      tick(v, b2g(last_b), "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
